// File: rtl/bounded_counter.sv
// Up/down bounded counter with WRAP/SAT/BOUNCE/HOLD boundary modes, clamped load and boundary pulse.
// Optional event counter output enabled by defining BOUNDED_COUNTER_EVENTS_EN.
module bounded_counter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP_W = 4,
    parameter int unsigned MAX    = 100,
    parameter int unsigned MIN    = 10,
    parameter int unsigned EV_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              set,
    input  logic [WIDTH-1:0]  din,
    input  logic [STEP_W-1:0] step,
    input  logic              up_down,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  count,
    output logic              dir,
    output logic              finish,
    output logic              bound_pulse
`ifdef BOUNDED_COUNTER_EVENTS_EN
    ,
    output logic [EV_W-1:0]   events
`endif
);

    localparam int unsigned CW = WIDTH + 2;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'd0,
        MODE_SAT    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    localparam logic [WIDTH-1:0]     MIN_W   = WIDTH'(MIN);
    localparam logic [WIDTH-1:0]     MAX_W   = WIDTH'(MAX);
    localparam logic signed [CW-1:0] MIN_X   = CW'(MIN);
    localparam logic signed [CW-1:0] MAX_X   = CW'(MAX);
    localparam logic signed [CW-1:0] MAXP1_X = CW'(MAX + 1);
    localparam logic signed [CW-1:0] MINM1_X = CW'(longint'(MIN) - 1);

    // Reject bound sets that cannot be represented or are empty.
    if ((MIN >= MAX) || (64'(MAX) >= (64'd1 << WIDTH)) || (EV_W == 0)) begin : g_param_check
        $error("bounded_counter: require MIN < MAX < 2**WIDTH and EV_W > 0");
    end

    mode_e                  mode_q;
    logic                   eff_dir;
    logic signed [CW-1:0]   cnt_x;
    logic signed [CW-1:0]   step_x;
    logic signed [CW-1:0]   nxt_up;
    logic signed [CW-1:0]   nxt_dn;
    logic signed [CW-1:0]   wrap_up;
    logic signed [CW-1:0]   wrap_dn;
    logic [WIDTH-1:0]       din_clamped;
    logic [WIDTH-1:0]       count_d;
    logic                   dir_d;
    logic                   pulse_d;

    assign mode_q  = mode_e'(mode);
    assign cnt_x   = CW'(count);
    assign step_x  = CW'(step);
    assign nxt_up  = cnt_x + step_x;
    assign nxt_dn  = cnt_x - step_x;
    assign wrap_up = MIN_X + (nxt_up - MAXP1_X);
    assign wrap_dn = MAX_X - (MINM1_X - nxt_dn);
    assign eff_dir = (mode_q == MODE_BOUNCE) ? dir : up_down;

    assign din_clamped = (din < MIN_W) ? MIN_W :
                         (din > MAX_W) ? MAX_W : din;

    // Next-state: load beats enabled update; HOLD and disabled cycles only clear the pulse.
    always_comb begin
        count_d = count;
        dir_d   = dir;
        pulse_d = 1'b0;
        if (set) begin
            count_d = din_clamped;
            dir_d   = up_down;
        end else if (en && (mode_q != MODE_HOLD)) begin
            if (eff_dir) begin
                pulse_d = (nxt_up >= MAX_X);
                if (nxt_up <= MAX_X) begin
                    count_d = WIDTH'(nxt_up);
                end else if (mode_q == MODE_WRAP) begin
                    count_d = (wrap_up > MAX_X) ? MIN_W : WIDTH'(wrap_up);
                end else begin
                    count_d = MAX_W;
                end
            end else begin
                pulse_d = (nxt_dn <= MIN_X);
                if (nxt_dn >= MIN_X) begin
                    count_d = WIDTH'(nxt_dn);
                end else if (mode_q == MODE_WRAP) begin
                    count_d = (wrap_dn < MIN_X) ? MAX_W : WIDTH'(wrap_dn);
                end else begin
                    count_d = MIN_W;
                end
            end
            if (mode_q == MODE_BOUNCE) begin
                dir_d = pulse_d ? ~dir : dir;
            end else begin
                dir_d = up_down;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= MIN_W;
            dir         <= 1'b1;
            bound_pulse <= 1'b0;
        end else begin
            count       <= count_d;
            dir         <= dir_d;
            bound_pulse <= pulse_d;
        end
    end

    assign finish = (count == MIN_W) || (count == MAX_W);

`ifdef BOUNDED_COUNTER_EVENTS_EN
    // Saturating count of boundary events since reset or last load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            events <= '0;
        end else if (set) begin
            events <= '0;
        end else if (pulse_d && (events != {EV_W{1'b1}})) begin
            events <= events + EV_W'(1);
        end
    end
`endif

endmodule
